// File: rtl/trace_pkg.sv
// Shared constants and FSM state encoding for the retire-trace capture block.
package trace_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t SEND = 2'd2;

  localparam int OPCODE_WIDTH = 6;
  localparam int REC_WIDTH    = 102;
  localparam int REC_NBYTES   = 13;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with show-ahead read; a push on a full FIFO succeeds when a pop frees the slot.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push_ok;
  logic         w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_rdat    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/trace_capture.sv
// Captures retired-instruction records into a FIFO and streams each one as 13 bytes
// over a valid/ready byte port; first byte appears 3 cycles after the commit.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     commit,
  input  logic [OPCODE_WIDTH-1:0]  opcode,
  input  logic [31:0]              operand1,
  input  logic [31:0]              operand2,
  input  logic [31:0]              result,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [7:0]               drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int         NBYTES   = REC_NBYTES;
  localparam int         SHIFT_W  = NBYTES * 8;
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  state_t                r_state;
  logic [3:0]            r_idx;
  logic [SHIFT_W-1:0]    r_shift;
  logic [7:0]            r_drop_cnt;

  logic [REC_WIDTH-1:0]  w_rec;
  logic [REC_WIDTH-1:0]  w_rdat;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_drop;

  assign w_rec  = {opcode, operand1, operand2, result};
  assign w_pop  = (r_state == LOAD);
  // A commit on a full FIFO survives only when the LOAD pop frees a slot that same edge.
  assign w_drop = commit && w_full && !w_pop;

  trace_fifo #(
    .W     (REC_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (commit),
    .i_wdat  (w_rec),
    .i_pop   (w_pop),
    .o_rdat  (w_rdat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_shift    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      case (r_state)
        IDLE: begin
          if (!w_empty) r_state <= LOAD;
        end
        LOAD: begin
          r_shift <= {2'b00, w_rdat};
          r_idx   <= '0;
          r_state <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            r_shift <= r_shift << 8;
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= w_empty ? IDLE : LOAD;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_valid   = (r_state == SEND);
  assign tx_data    = r_shift[SHIFT_W-1 -: 8];
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: latency, backpressure, overflow, saturation and reset.
module tb_trace_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit;
  logic [5:0]  opcode;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [31:0] result;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  drop_count;
  logic [3:0]  fifo_level;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  rx_q  [$];
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  trace_capture #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .commit     (commit),
    .opcode     (opcode),
    .operand1   (operand1),
    .operand2   (operand2),
    .result     (result),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r);
    logic [103:0] v;
    v = {2'b00, op, a, b, r};
    for (int k = 0; k < 13; k++) exp_q.push_back(v[103-8*k -: 8]);
  endtask

  // Entered and left on a falling edge; the record is captured at the rising edge between.
  task automatic commit_rec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input bit keep);
    commit = 1'b1; opcode = op; operand1 = a; operand2 = b; result = r;
    if (keep) push_exp(op, a, b, r);
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk(tag, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] t1 [13];
    t1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
           8'h03, 8'h00, 8'h00, 8'h00, 8'h08};
    rst_n = 1'b0; commit = 1'b0; opcode = '0; operand1 = '0; operand2 = '0; result = '0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data",  tx_data,  8'h00);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_drop",  drop_count, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single record and 3-cycle latency
    commit_rec(6'h00, 32'd5, 32'd3, 32'd8, 1'b0);
    for (int k = 0; k < 13; k++) exp_q.push_back(t1[k]);
    chk("lat_c1_valid", tx_valid, 1'b0);
    chk("lat_c1_level", fifo_level, 4'd1);
    @(negedge clk);
    chk("lat_c2_valid", tx_valid, 1'b0);
    @(negedge clk);
    chk("lat_c3_valid", tx_valid, 1'b1);
    chk("lat_c3_data",  tx_data, 8'h00);
    wait_rx("single_wait", 13);
    repeat (5) @(negedge clk);
    check_stream("single");

    // Backpressure while byte 4 is presented
    commit_rec(6'h2A, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 1'b1);
    wait_rx("bp_wait4", 4);
    tx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("bp_data",  tx_data, 8'hEF);
      chk("bp_valid", tx_valid, 1'b1);
      @(negedge clk);
    end
    chk("bp_held_cnt", rx_q.size(), 4);
    tx_ready = 1'b1;
    wait_rx("bp_wait13", 13);
    repeat (3) @(negedge clk);
    check_stream("bp");

    // Overflow: 12 commits under backpressure, 3 dropped
    tx_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      commit = 1'b1; opcode = 6'(i + 1); operand1 = 32'h1111_0000 + i;
      operand2 = 32'hA5A5_0000 ^ i; result = i * 7;
      if (i < 9) push_exp(6'(i + 1), 32'h1111_0000 + i, 32'hA5A5_0000 ^ i, i * 7);
      @(negedge clk);
    end
    commit = 1'b0;
    chk("ovf_level", fifo_level, 4'd8);
    chk("ovf_drop",  drop_count, 8'd3);

    // Push during LOAD with a full FIFO is accepted
    tx_ready = 1'b1;
    wait_rx("ovf_first", 13);
    chk("load_valid", tx_valid, 1'b0);
    chk("load_level", fifo_level, 4'd8);
    commit_rec(6'h3F, 32'hCAFE_F00D, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    chk("pp_level", fifo_level, 4'd8);
    chk("pp_drop",  drop_count, 8'd3);
    wait_rx("ovf_all", 130);
    repeat (3) @(negedge clk);
    chk("ovf_drain_level", fifo_level, 4'd0);
    check_stream("ovf");

    // Drop counter saturation
    tx_ready = 1'b0;
    for (int i = 0; i < 320; i++) begin
      commit = 1'b1; opcode = i[5:0]; operand1 = i; operand2 = ~i; result = i;
      @(negedge clk);
    end
    commit = 1'b0;
    chk("sat_drop",  drop_count, 8'd255);
    chk("sat_level", fifo_level, 4'd8);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("sat_rst_drop", drop_count, 8'd0);
    rx_q.delete();
    exp_q.delete();
    tx_ready = 1'b1;
    @(negedge clk);

    // Reset while byte 7 is presented, with commit held during reset
    commit_rec(6'h15, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 1'b0);
    wait_rx("mid_wait7", 7);
    rst_n = 1'b0; commit = 1'b1; opcode = 6'h01;
    @(negedge clk);
    commit = 1'b0; rst_n = 1'b1;
    chk("mid_rst_valid", tx_valid, 1'b0);
    chk("mid_rst_level", fifo_level, 4'd0);
    chk("mid_rst_data",  tx_data, 8'h00);
    rx_q.delete();
    repeat (4) @(negedge clk);
    chk("mid_quiet", rx_q.size(), 0);
    commit_rec(6'h33, 32'h7654_3210, 32'h0F0F_0F0F, 32'h1357_9BDF, 1'b1);
    wait_rx("mid_wait13", 13);
    repeat (3) @(negedge clk);
    check_stream("mid_new");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
